mem_bus_arbiter: RTL and testbench

- Shares one sram-like memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Runs one outstanding transaction at a time, using a req / addr_ok / data_ok handshake on every port.
- Grants with data priority, and alternates round-robin when both ports wait.
- Drives per-port stall requests that the pipeline stall controller consumes as stallreq inputs.

---
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one sram-like bus between the IF and MEM ports. Runs one
//            transaction at a time, favours data, and round-robins on contention.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction-fetch port
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    // data port
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    // downstream bus
    output logic                bus_req,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    // pipeline stall requests
    output logic                stallreq_inst,
    output logic                stallreq_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner;        // 0 = inst, 1 = data
    logic                r_last_owner;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_grant;
    logic                w_grant_data;
    logic                w_addr_acc;
    logic                w_data_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_data;
                r_wr    <= w_grant_data & data_wr;
                r_addr  <= w_grant_data ? data_addr  : inst_addr;
                r_wstrb <= w_grant_data ? data_wstrb : '0;
                r_wdata <= w_grant_data ? data_wdata : '0;
            end
            if (w_addr_acc) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Grant is only evaluated in IDLE, so a completion never overlaps a new grant.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_addr_acc   = 1'b0;
        w_data_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (inst_req || data_req) begin
                    w_grant      = 1'b1;
                    w_grant_data = data_req & (~inst_req | ~r_last_owner);
                    w_state_nxt  = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (bus_addr_ok) begin
                    w_addr_acc  = 1'b1;
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (bus_data_ok) begin
                    w_data_done = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are forced low while resetn is asserted, even before the first edge.
    assign bus_req   = resetn & (r_state == c_ST_ADDR);
    assign bus_wr    = resetn & r_wr;
    assign bus_addr  = resetn ? r_addr  : '0;
    assign bus_wstrb = resetn ? r_wstrb : '0;
    assign bus_wdata = resetn ? r_wdata : '0;

    assign inst_addr_ok = resetn & w_addr_acc  & ~r_owner;
    assign data_addr_ok = resetn & w_addr_acc  &  r_owner;
    assign inst_data_ok = resetn & w_data_done & ~r_owner;
    assign data_data_ok = resetn & w_data_done &  r_owner;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    assign stallreq_inst = resetn & ((inst_req & ~inst_addr_ok) |
                           (~r_owner & (r_state == c_ST_DATA) & ~bus_data_ok));
    assign stallreq_data = resetn & ((data_req & ~data_addr_ok) |
                           ( r_owner & (r_state == c_ST_DATA) & ~bus_data_ok));

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed reset/read/write cases, then random two-port traffic
//            against a transaction-level arbitration and memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int c_NTX = 40;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stallreq_inst, stallreq_data;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen through the bus: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h2408_0001;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    txn_t q_inst[$];
    txn_t q_data[$];
    txn_t cur;
    logic mon_en = 1'b0;
    int   ph = 0;           // 0 bus free, 1 address phase, 2 data phase
    logic m_owner = 1'b0;   // 1 = data port owns the current transaction
    logic m_last = 1'b0;
    int   n_done = 0;
    logic e_iaok, e_daok, e_idok, e_ddok, e_win;

    always @(negedge clk) begin
        if (mon_en) begin
            e_iaok = (ph == 1) && bus_addr_ok && !m_owner;
            e_daok = (ph == 1) && bus_addr_ok &&  m_owner;
            e_idok = (ph == 2) && bus_data_ok && !m_owner;
            e_ddok = (ph == 2) && bus_data_ok &&  m_owner;
            chk("bus_req", 32'(bus_req), 32'(ph == 1));
            if (ph == 1) begin
                chk("bus_addr",  bus_addr,         cur.addr);
                chk("bus_wr",    32'(bus_wr),      32'(cur.wr));
                chk("bus_wstrb", 32'(bus_wstrb),   32'(cur.wstrb));
                if (cur.wr) chk("bus_wdata", bus_wdata, cur.wdata);
            end
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
            chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
            chk("inst_rdata", inst_rdata, e_idok ? mem_word(cur.addr) : 32'h0);
            if (!(e_ddok && cur.wr))
                chk("data_rdata", data_rdata, e_ddok ? mem_word(cur.addr) : 32'h0);
            chk("stallreq_inst", 32'(stallreq_inst),
                32'((inst_req && !e_iaok) || (ph == 2 && !m_owner && !bus_data_ok)));
            chk("stallreq_data", 32'(stallreq_data),
                32'((data_req && !e_daok) || (ph == 2 &&  m_owner && !bus_data_ok)));
            case (ph)
                0: if (inst_req || data_req) begin
                    // data wins unless data had the previous grant and inst also waits
                    e_win = data_req && (!inst_req || !m_last);
                    if (e_win && q_data.size() > 0) cur = q_data.pop_front();
                    else if (!e_win && q_inst.size() > 0) cur = q_inst.pop_front();
                    else chk("scoreboard_underflow", 32'(1), 32'(0));
                    m_owner = e_win;
                    ph = 1;
                end
                1: if (bus_addr_ok) begin
                    m_last = m_owner;
                    ph = 2;
                end
                default: if (bus_data_ok) begin
                    ph = 0;
                    n_done++;
                end
            endcase
        end
    end

    // ---------------- random bus slave ----------------
    logic        slave_en = 1'b0;
    logic        s_pend = 1'b0;
    logic [31:0] s_addr = 32'h0;

    always @(negedge clk) begin
        if (slave_en) begin
            if (bus_req && bus_addr_ok) begin
                s_pend = 1'b1;
                s_addr = bus_addr;
            end else if (s_pend && bus_data_ok) begin
                s_pend = 1'b0;
            end
        end
    end

    // Spurious handshakes outside the matching phase exercise the "ignored" rules.
    always @(posedge clk) begin
        if (slave_en) begin
            #1;
            bus_addr_ok = bus_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) == 0);
            bus_data_ok = s_pend  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus_rdata   = s_pend  ? mem_word(s_addr) : $urandom;
        end
    end

    // ---------------- random port drivers ----------------
    task automatic drive_inst();
        txn_t t;
        bit   got;
        for (int n = 0; n < c_NTX; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            t.wr    = 1'b0;
            t.addr  = ($urandom_range(0, 3) == 0) ? 32'hBFC0_0000 : ($urandom & 32'hFFFF_FFFC);
            t.wstrb = 4'h0;
            t.wdata = 32'h0;
            q_inst.push_back(t);
            inst_addr = t.addr;
            inst_req  = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (inst_addr_ok) got = 1'b1;
            end
            if (!got) chk("inst_grant_timeout", 32'(0), 32'(1));
            @(posedge clk);
            #1;
            inst_req  = 1'b0;
            inst_addr = $urandom;
        end
    endtask

    task automatic drive_data();
        txn_t t;
        bit   got;
        for (int n = 0; n < c_NTX; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            t.wr    = 1'($urandom_range(0, 1));
            t.addr  = ($urandom_range(0, 3) == 0) ? 32'h8000_1000 : ($urandom & 32'hFFFF_FFFC);
            t.wstrb = 4'($urandom_range(0, 15));
            t.wdata = $urandom;
            q_data.push_back(t);
            data_wr    = t.wr;
            data_addr  = t.addr;
            data_wstrb = t.wstrb;
            data_wdata = t.wdata;
            data_req   = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (data_addr_ok) got = 1'b1;
            end
            if (!got) chk("data_grant_timeout", 32'(0), 32'(1));
            @(posedge clk);
            #1;
            data_req   = 1'b0;
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
    endtask

    task automatic expect_all_low(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), 32'(0));
        chk({tag, "_aok"}, 32'({inst_addr_ok, data_addr_ok}), 32'(0));
        chk({tag, "_dok"}, 32'({inst_data_ok, data_data_ok}), 32'(0));
        chk({tag, "_stall"}, 32'({stallreq_inst, stallreq_data}), 32'(0));
        chk({tag, "_rdata"}, inst_rdata | data_rdata, 32'h0);
    endtask

    // ---------------- directed sequence, then random traffic ----------------
    initial begin
        resetn = 1'b0;
        inst_req = 1'b1;  inst_addr = 32'hBFC0_0000;
        data_req = 1'b1;  data_wr = 1'b1;  data_addr = 32'h8000_1000;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h1234_5678;

        repeat (2) begin
            @(posedge clk); @(negedge clk);
            expect_all_low("rst");
            chk("rst_bus_addr", bus_addr, 32'h0);
        end
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("idle_bus_req", 32'(bus_req), 32'(0));
        chk("idle_stalls", 32'({stallreq_inst, stallreq_data}), 32'(3));

        // first grant after reset goes to data; write fields held under backpressure
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("wr_bus_req", 32'(bus_req), 32'(1));
            chk("wr_bus_addr", bus_addr, 32'h8000_1000);
            chk("wr_bus_fields", {bus_wdata[27:0], bus_wr, 3'b000} ^ 32'(bus_wstrb),
                {28'hEAD_BEEF, 1'b1, 3'b000} ^ 32'hF);
            chk("wr_stall_data", 32'(stallreq_data), 32'(1));
            @(posedge clk);
        end
        #1 bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("wr_aok", 32'({inst_addr_ok, data_addr_ok}), 32'(1));
        @(posedge clk); #1 bus_addr_ok = 1'b0; data_req = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("wr_data_stall", 32'({bus_req, stallreq_inst, stallreq_data}), 32'(1));

        // reset in the middle of the data phase, late completion must be dropped
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        expect_all_low("mid_rst");
        @(posedge clk); #1 resetn = 1'b1; bus_data_ok = 1'b1;
        @(negedge clk);
        expect_all_low("post_rst_dok");
        @(posedge clk); #1 bus_data_ok = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus_req), 32'(0));

        // single instruction read
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        @(posedge clk); #1 bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("rd_aok", 32'({inst_addr_ok, data_addr_ok}), 32'(2));
        chk("rd_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("rd_bus_wr_wstrb", 32'({bus_wr, bus_wstrb}), 32'(0));
        @(posedge clk); #1 bus_addr_ok = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("rd_wait", 32'({inst_data_ok, stallreq_inst}), 32'(1));
        @(posedge clk); #1 bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
        @(negedge clk);
        chk("rd_dok", 32'({inst_data_ok, data_data_ok, stallreq_inst}), 32'(4));
        chk("rd_inst_rdata", inst_rdata, 32'h2408_0001);
        chk("rd_data_rdata", data_rdata, 32'h0);
        @(posedge clk); #1 bus_data_ok = 1'b0;

        // random two-port traffic; last grant went to inst
        ph = 0; m_last = 1'b0; mon_en = 1'b1; slave_en = 1'b1;
        fork
            drive_inst();
            drive_data();
        join
        for (int c = 0; c < 300 && ph != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("txn_count", 32'(n_done), 32'(2 * c_NTX));
        chk("queues_empty", 32'(q_inst.size() + q_data.size()), 32'(0));
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
